// File: rtl/crop_frame_buffer.sv
// crop_frame_buffer: stores one downsampled frame and
// drains it byte-by-byte to the serial transmitter.
module crop_frame_buffer #(
  parameter int NUM_PX = 784,
  parameter int DATA_W = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCLR,
  input  logic              iDVAL,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iSEND,
  output logic [DATA_W-1:0] oTX_DATA,
  output logic              oTX_VALID,
  input  logic              iTX_READY,
  output logic              oFULL,
  output logic              oBUSY,
  output logic [9:0]        oCOUNT,
  output logic              oOVF
);

  localparam logic [9:0] LAST = 10'(NUM_PX - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          wr_ptr_q, wr_ptr_d;
  logic [9:0]          rd_ptr_q, rd_ptr_d;
  logic [9:0]          cnt_q, cnt_d;
  logic                vld_q, vld_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                we;

  logic [DATA_W-1:0]   mem [NUM_PX];

  // Frame storage; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (we) mem[wr_ptr_q] <= iDATA;
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= S_FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: restart wins, then fill / hold / drain.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    we       = 1'b0;
    if (iCLR) begin
      state_d  = S_FILL;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      vld_d    = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_FILL: begin
          if (iDVAL) begin
            we    = 1'b1;
            cnt_d = cnt_q + 10'd1;
            if (wr_ptr_q == LAST) begin
              wr_ptr_d = '0;
              state_d  = S_FULL;
            end else begin
              wr_ptr_d = wr_ptr_q + 10'd1;
            end
          end
        end
        S_FULL: begin
          if (iDVAL) ovf_d = 1'b1;
          if (iSEND) begin
            state_d  = S_DRAIN;
            rd_ptr_d = '0;
            vld_d    = 1'b0;
          end
        end
        S_DRAIN: begin
          if (iDVAL) ovf_d = 1'b1;
          if (!vld_q) begin
            vld_d  = 1'b1;
            data_d = mem[rd_ptr_q];
          end else if (iTX_READY) begin
            vld_d = 1'b0;
            if (rd_ptr_q == LAST) begin
              state_d  = S_FILL;
              rd_ptr_d = '0;
              wr_ptr_d = '0;
              cnt_d    = '0;
            end else begin
              rd_ptr_d = rd_ptr_q + 10'd1;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  assign oTX_DATA  = data_q;
  assign oTX_VALID = vld_q;
  assign oFULL     = (state_q == S_FULL) || (state_q == S_DRAIN);
  assign oBUSY     = (state_q == S_DRAIN);
  assign oCOUNT    = cnt_q;
  assign oOVF      = ovf_q;

endmodule

// File: tb/tb_crop_frame_buffer.sv
// tb_crop_frame_buffer: directed checks of fill, drain,
// backpressure, overflow, abort and mid-fill reset.
module tb_crop_frame_buffer;

  localparam int NPX = 784;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b0;
  logic       iCLR = 1'b0;
  logic       iDVAL = 1'b0;
  logic [7:0] iDATA = '0;
  logic       iSEND = 1'b0;
  logic       iTX_READY = 1'b0;
  logic [7:0] oTX_DATA;
  logic       oTX_VALID;
  logic       oFULL;
  logic       oBUSY;
  logic [9:0] oCOUNT;
  logic       oOVF;

  int n_chk = 0;
  int n_fail = 0;

  crop_frame_buffer #(.NUM_PX(NPX), .DATA_W(8)) dut (
    .iCLK(iCLK), .iRST(iRST), .iCLR(iCLR),
    .iDVAL(iDVAL), .iDATA(iDATA), .iSEND(iSEND),
    .oTX_DATA(oTX_DATA), .oTX_VALID(oTX_VALID),
    .iTX_READY(iTX_READY), .oFULL(oFULL), .oBUSY(oBUSY),
    .oCOUNT(oCOUNT), .oOVF(oOVF)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(oTX_DATA), 0);
    chk({tag, "_valid"}, 32'(oTX_VALID), 0);
    chk({tag, "_full"}, 32'(oFULL), 0);
    chk({tag, "_busy"}, 32'(oBUSY), 0);
    chk({tag, "_count"}, 32'(oCOUNT), 0);
    chk({tag, "_ovf"}, 32'(oOVF), 0);
  endtask

  // Write pixels first..last-1 with value (i ^ key), irregular gaps.
  task automatic fill(input int first, input int last,
                      input logic [7:0] key);
    for (int i = first; i < last; i++) begin
      iDVAL = 1'b1;
      iDATA = 8'(i) ^ key;
      step();
      iDVAL = 1'b0;
      chk("fill_count", 32'(oCOUNT), 32'(i + 1));
      chk("fill_full", 32'(oFULL), 32'(i == NPX - 1));
      repeat (i % 3) step();
    end
  endtask

  // Drain and check bytes; optional stall and early stop.
  task automatic drain(input logic [7:0] key, input int stall_at,
                       input int stop_at);
    iTX_READY = 1'b1;
    iSEND = 1'b1;
    step();
    iSEND = 1'b0;
    chk("send_busy", 32'(oBUSY), 1);
    chk("send_valid", 32'(oTX_VALID), 0);
    step();
    chk("first_valid", 32'(oTX_VALID), 1);
    for (int k = 0; k < NPX; k++) begin
      chk("byte_data", 32'(oTX_DATA), 32'(8'(k) ^ key));
      if (k == stop_at) return;
      if (k == stall_at) begin
        iTX_READY = 1'b0;
        for (int s = 0; s < 10; s++) begin
          step();
          chk("stall_valid", 32'(oTX_VALID), 1);
          chk("stall_data", 32'(oTX_DATA), 32'(8'(k) ^ key));
        end
        iTX_READY = 1'b1;
      end
      step();
      chk("xfer_valid_low", 32'(oTX_VALID), 0);
      if (k == NPX - 1) begin
        chk("end_full", 32'(oFULL), 0);
        chk("end_busy", 32'(oBUSY), 0);
        chk("end_count", 32'(oCOUNT), 0);
      end else begin
        chk("drain_count", 32'(oCOUNT), NPX);
        chk("drain_busy", 32'(oBUSY), 1);
        step();
        chk("next_valid", 32'(oTX_VALID), 1);
      end
    end
  endtask

  initial begin
    // Reset state
    #3;
    chk_zero("rst");
    step();
    chk_zero("rst_clk");
    iRST = 1'b1;
    step();
    chk_zero("post_rst");

    // iSEND ignored while filling
    iSEND = 1'b1;
    step();
    iSEND = 1'b0;
    chk("send_in_fill_busy", 32'(oBUSY), 0);
    chk("send_in_fill_valid", 32'(oTX_VALID), 0);

    // Full frame fill
    fill(0, NPX, 8'h00);
    chk("fill_ovf", 32'(oOVF), 0);

    // Overflow: three strobes while full
    for (int j = 0; j < 3; j++) begin
      iDVAL = 1'b1;
      iDATA = 8'hEE;
      step();
      iDVAL = 1'b0;
      step();
    end
    chk("ovf_set", 32'(oOVF), 1);
    chk("ovf_count", 32'(oCOUNT), NPX);
    chk("ovf_full", 32'(oFULL), 1);

    // Drain with backpressure at byte 100; data is original
    drain(8'h00, 100, -1);
    chk("ovf_sticky", 32'(oOVF), 1);
    iCLR = 1'b1;
    step();
    iCLR = 1'b0;
    chk("clr_ovf", 32'(oOVF), 0);

    // Abort at byte 300 with coincident iDVAL
    fill(0, NPX, 8'h5A);
    drain(8'h5A, -1, 300);
    iCLR = 1'b1;
    iDVAL = 1'b1;
    iDATA = 8'h77;
    step();
    iCLR = 1'b0;
    iDVAL = 1'b0;
    chk("abort_valid", 32'(oTX_VALID), 0);
    chk("abort_busy", 32'(oBUSY), 0);
    chk("abort_full", 32'(oFULL), 0);
    chk("abort_count", 32'(oCOUNT), 0);
    step();
    chk("abort_quiet", 32'(oTX_VALID), 0);
    iDVAL = 1'b1;
    iDATA = 8'hAB;
    step();
    iDVAL = 1'b0;
    chk("abort_wr_count", 32'(oCOUNT), 1);
    fill(1, NPX, 8'h00);
    iTX_READY = 1'b1;
    iSEND = 1'b1;
    step();
    iSEND = 1'b0;
    step();
    chk("abort_addr0_valid", 32'(oTX_VALID), 1);
    chk("abort_addr0_data", 32'(oTX_DATA), 32'h0AB);
    step();
    step();
    chk("abort_addr1_data", 32'(oTX_DATA), 1);

    // Asynchronous reset mid-fill
    iCLR = 1'b1;
    step();
    iCLR = 1'b0;
    fill(0, 400, 8'h33);
    chk("midfill_count", 32'(oCOUNT), 400);
    #2;
    iRST = 1'b0;
    #1;
    chk_zero("async_rst");
    #3;
    iRST = 1'b1;
    step();
    chk_zero("rst_release");
    fill(0, NPX, 8'hC3);
    drain(8'hC3, -1, -1);
    chk("final_full", 32'(oFULL), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/crop_frame_buffer.md
CROP_FRAME_BUFFER -- requirements
Module: crop_frame_buffer

Interface
REQ-001 Parameter NUM_PX, default 784: pixels per downsampled frame (28 x 28).
REQ-002 Parameter DATA_W, default 8: pixel width in bits.
REQ-003 iCLK  input  1  system clock; all state changes on the rising edge.
REQ-004 iRST  input  1  asynchronous, active-low reset.
REQ-005 iCLR  input  1  synchronous frame restart, active-high; pulses at the start of each camera frame.
REQ-006 iDVAL  input  1  incoming pixel valid; single-cycle strobes from the crop/downsample stage.
REQ-007 iDATA  input  DATA_W  incoming pixel value, sampled when iDVAL=1.
REQ-008 iSEND  input  1  request to drain a full frame to the serial transmitter.
REQ-009 oTX_DATA  output  DATA_W  byte offered to the SPART transmitter.
REQ-010 oTX_VALID  output  1  oTX_DATA is valid.
REQ-011 iTX_READY  input  1  transmitter accepts the byte; a transfer occurs on an edge where oTX_VALID=1 and iTX_READY=1.
REQ-012 oFULL  output  1  a complete frame is stored and not yet drained.
REQ-013 oBUSY  output  1  drain in progress.
REQ-014 oCOUNT  output  10  number of pixels stored in the current frame.
REQ-015 oOVF  output  1  sticky flag: a pixel was dropped.

Function
REQ-016 Internal storage SHALL be NUM_PX x DATA_W words with a write pointer and a read pointer, each 10 bits and ranging 0..NUM_PX-1.
REQ-017 States SHALL be FILL, FULL and DRAIN; the reset state SHALL be FILL.
REQ-018 In FILL, on iDVAL=1 the block SHALL write iDATA to mem[wr_ptr] and increment wr_ptr and oCOUNT on the same edge.
REQ-019 When oCOUNT reaches NUM_PX, the block SHALL transition FILL->FULL and set oFULL=1 on the same edge that writes the last pixel.
REQ-020 In FULL and DRAIN, iDVAL=1 SHALL be ignored with no write, and oOVF SHALL be set to 1.
REQ-021 iSEND SHALL be honoured only in FULL; it SHALL be ignored in FILL and DRAIN.
REQ-022 On iSEND in FULL at edge N: state becomes DRAIN, oBUSY=1, rd_ptr=0.
REQ-023 Memory reads SHALL be registered, so oTX_VALID asserts at edge N+1 with oTX_DATA=mem[0].
REQ-024 While oTX_VALID=1 and iTX_READY=0, oTX_VALID and oTX_DATA SHALL be held stable.
REQ-025 On a transfer at edge M: rd_ptr increments, and oTX_VALID deasserts for one cycle.
REQ-026 After a transfer, the next byte SHALL be presented at edge M+1, giving a maximum rate of one byte per 2 cycles.
REQ-027 Bytes SHALL be sent in write order, index 0 to NUM_PX-1, with no duplicates and no omissions.
REQ-028 On transfer of byte NUM_PX-1, on the same edge the block SHALL: return to FILL, clear oFULL, oBUSY, oCOUNT, wr_ptr and rd_ptr, and deassert oTX_VALID.
REQ-029 oCOUNT SHALL hold NUM_PX throughout DRAIN.
REQ-030 iCLR=1 SHALL have priority over all other inputs in any state.
REQ-031 On iCLR=1, on the next edge the block SHALL: enter FILL, clear both pointers, oCOUNT, oFULL, oBUSY, oTX_VALID and oOVF, and perform no write on that edge even if iDVAL=1.
REQ-032 An iCLR during DRAIN SHALL abort the drain immediately; no further bytes are offered.
REQ-033 oOVF SHALL be cleared only by reset or iCLR.
REQ-034 oCOUNT SHALL never exceed NUM_PX, and pointers SHALL never address beyond NUM_PX-1.

Reset
REQ-035 While iRST=0, outputs SHALL be: oTX_DATA=0, oTX_VALID=0, oFULL=0, oBUSY=0, oCOUNT=0, oOVF=0.
REQ-036 While iRST=0, state SHALL be FILL and both pointers SHALL be 0.
REQ-037 Memory contents need not be cleared by reset.
REQ-038 Reset SHALL apply asynchronously; release SHALL be synchronous to iCLK, and operation SHALL resume from FILL.

Verification
REQ-039 Fill: 784 strobes with iDATA=index mod 256, spaced irregularly -> oCOUNT increments per strobe; oFULL=1 on the edge writing pixel 783; oOVF=0.
REQ-040 Drain with iTX_READY tied 1 after fill, iSEND pulse -> exactly 784 bytes with values 0,1,...,255,0,...,15; first oTX_VALID 1 cycle after iSEND; oFULL=0 after the last byte.
REQ-041 Backpressure: iTX_READY held 0 for 10 cycles mid-drain at byte 100 -> oTX_DATA stays 100 and oTX_VALID stays 1 throughout the stall; no byte is lost or repeated.
REQ-042 Overflow: 3 extra iDVAL strobes in FULL -> oOVF=1, memory unchanged (drain still yields the original data), oCOUNT=784; the next iCLR clears oOVF.
REQ-043 Abort: iCLR at byte 300 of a drain, coincident with iDVAL=1 -> oTX_VALID=0 on the next edge; state FILL; oCOUNT=0; the following strobe is written to address 0.
REQ-044 Reset mid-fill: iRST=0 asynchronously at oCOUNT=400 -> all outputs go to 0 immediately; after release, a full 784-pixel fill and drain operate correctly.
